// File: rtl/regfile_pkg.sv
// regfile_sb shared types and defaults.
// State encoding for the bulk-clear sequencer.
package regfile_pkg;

  localparam int RF_DATA_W = 24;
  localparam int RF_DEPTH  = 8;
  localparam int RF_NUM_RD = 2;

  typedef enum logic {
    RF_IDLE,
    RF_CLEAR
  } rf_state_e;

endpackage

// File: rtl/regfile_sb_if.sv
// Bus between decode/writeback and the register file.
// master drives requests, slave returns operands.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int DEPTH  = RF_DEPTH,
  parameter int NUM_RD = RF_NUM_RD
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                     we;
  logic [ADDR_W-1:0]        wa;
  logic [DATA_W-1:0]        wd;
  logic [NUM_RD*ADDR_W-1:0] ra;
  logic [NUM_RD*DATA_W-1:0] rd;
  logic [NUM_RD-1:0]        rdy;
  logic                     alloc_en;
  logic [ADDR_W-1:0]        alloc_addr;
  logic                     clr_req;
  logic                     clr_busy;

  modport master (
    output we, wa, wd, ra,
    output alloc_en, alloc_addr, clr_req,
    input  rd, rdy, clr_busy
  );

  modport slave (
    input  we, wa, wd, ra,
    input  alloc_en, alloc_addr, clr_req,
    output rd, rdy, clr_busy
  );

endinterface

// File: rtl/regfile_rdport.sv
// One combinational read port: zero detect,
// write bypass and operand-ready flag.
module regfile_rdport #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 3
) (
  input  logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] arr,
  input  logic              pend,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              idle,
  output logic [DATA_W-1:0] rd,
  output logic              rdy
);

  logic zero;
  logic hit;

  assign zero = (ra == '0);
  assign hit  = we && idle && (wa == ra) && !zero;

  // Select operand source and readiness
  always_comb begin
    rd  = arr;
    rdy = !pend;
    unique case (1'b1)
      zero: begin
        rd  = '0;
        rdy = 1'b1;
      end
      hit: begin
        rd  = wd;
        rdy = 1'b1;
      end
      default: begin
        rd  = arr;
        rdy = !pend;
      end
    endcase
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with bypass, pending-write
// scoreboard and sequenced bulk clear.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int DEPTH  = RF_DEPTH,
  parameter int NUM_RD = RF_NUM_RD
) (
  input  logic        clk,
  input  logic        rst,
  regfile_sb_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  rf_state_e         state;
  rf_state_e         state_d;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              idle;
  logic              wr_ok;
  logic              al_ok;

  logic [NUM_RD*DATA_W-1:0] rd_v;
  logic [NUM_RD-1:0]        rdy_v;

  assign idle  = (state == RF_IDLE);
  assign wr_ok = idle && bus.we && (bus.wa != '0);
  assign al_ok = idle && bus.alloc_en
              && (bus.alloc_addr != '0);

  // Clear sequencer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RF_IDLE;
    else      state <= state_d;
  end

  // Clear sequencer next state
  always_comb begin
    state_d = state;
    case (state)
      RF_IDLE:  if (bus.clr_req) state_d = RF_CLEAR;
      RF_CLEAR: if (idx == LAST) state_d = RF_IDLE;
      default:  state_d = RF_IDLE;
    endcase
  end

  // Register array: writeback or clear sweep
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[bus.wa] <= bus.wd;
    end else if (!idle) begin
      regs[idx] <= '0;
    end
  end

  // Scoreboard and clear index; alloc beats write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
      idx  <= ONE;
    end else if (idle) begin
      if (bus.clr_req) begin
        busy <= '0;
        idx  <= ONE;
      end else begin
        if (wr_ok) busy[bus.wa] <= 1'b0;
        if (al_ok) busy[bus.alloc_addr] <= 1'b1;
      end
    end else begin
      idx <= idx + ONE;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = bus.ra[i*ADDR_W +: ADDR_W];

    regfile_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rdport (
      .ra   (a),
      .arr  (regs[a]),
      .pend (busy[a]),
      .we   (bus.we),
      .wa   (bus.wa),
      .wd   (bus.wd),
      .idle (idle),
      .rd   (rd_v[i*DATA_W +: DATA_W]),
      .rdy  (rdy_v[i])
    );
  end

  assign bus.rd       = rd_v;
  assign bus.rdy      = rdy_v;
  assign bus.clr_busy = !idle;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: default
// instance plus a 32x16, 3-port instance.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  regfile_sb_if u_if0 ();
  regfile_sb_if #(
    .DATA_W (32),
    .DEPTH  (16),
    .NUM_RD (3)
  ) u_if1 ();

  regfile_sb u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (u_if0.slave)
  );

  regfile_sb #(
    .DATA_W (32),
    .DEPTH  (16),
    .NUM_RD (3)
  ) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (u_if1.slave)
  );

  // kind: 0 = rd port, 1 = rdy vector, 2 = clr_busy
  typedef struct {
    string       name;
    int          inst;
    int          kind;
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  task automatic expect_v(input string n, input int inst,
                          input int kind, input int port,
                          input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.inst = inst;
    e.kind = kind;
    e.port = port;
    e.val  = v;
    q.push_back(e);
  endtask

  function automatic logic [31:0] sample(input exp_t e);
    logic [31:0] r;
    r = '0;
    if (e.inst == 0) begin
      case (e.kind)
        0:       r = 32'(u_if0.rd[e.port*24 +: 24]);
        1:       r = 32'(u_if0.rdy);
        default: r = 32'(u_if0.clr_busy);
      endcase
    end else begin
      case (e.kind)
        0:       r = u_if1.rd[e.port*32 +: 32];
        1:       r = 32'(u_if1.rdy);
        default: r = 32'(u_if1.clr_busy);
      endcase
    end
    return r;
  endfunction

  // Monitor: compare every queued expectation mid-cycle
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0) begin
      e   = q.pop_front();
      act = sample(e);
      checks++;
      if (act !== e.val) begin
        failures++;
        $display("FAIL %s inst=%0d port=%0d got=%h exp=%h",
                 e.name, e.inst, e.port, act, e.val);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet0();
    u_if0.we       = 1'b0;
    u_if0.alloc_en = 1'b0;
    u_if0.clr_req  = 1'b0;
  endtask

  task automatic ra0(input int a1, input int a0);
    u_if0.ra = {3'(a1), 3'(a0)};
  endtask

  task automatic wr0(input int a, input logic [23:0] d);
    u_if0.we = 1'b1;
    u_if0.wa = 3'(a);
    u_if0.wd = d;
  endtask

  initial begin
    u_if0.we = 0; u_if0.wa = 0; u_if0.wd = 0;
    u_if0.alloc_en = 0; u_if0.alloc_addr = 0;
    u_if0.clr_req = 0;
    u_if1.we = 0; u_if1.wa = 0; u_if1.wd = 0;
    u_if1.alloc_en = 0; u_if1.alloc_addr = 0;
    u_if1.clr_req = 0; u_if1.ra = '0;
    ra0(5, 3);
    #2;
    expect_v("rst_rd0", 0, 0, 0, 32'h0);
    expect_v("rst_rd1", 0, 0, 1, 32'h0);
    expect_v("rst_rdy", 0, 1, 0, 32'h3);
    expect_v("rst_busy", 0, 2, 0, 32'h0);
    cyc();
    rst = 1'b1;

    // write then read through the array
    cyc(); wr0(3, 24'hABCDEF); ra0(0, 0);
    cyc(); quiet0(); ra0(5, 3);
    expect_v("arr_r3", 0, 0, 0, 32'hABCDEF);
    expect_v("arr_r5", 0, 0, 1, 32'h0);

    // bypass and write to r0
    cyc(); wr0(4, 24'h123456); ra0(4, 3);
    expect_v("byp_rd1", 0, 0, 1, 32'h123456);
    expect_v("byp_rd0", 0, 0, 0, 32'hABCDEF);
    cyc(); wr0(0, 24'hFFFFFF); ra0(0, 0);
    expect_v("r0_byp", 0, 0, 0, 32'h0);
    cyc(); quiet0(); ra0(0, 4);
    expect_v("r4_arr", 0, 0, 0, 32'h123456);
    expect_v("r0_arr", 0, 0, 1, 32'h0);

    // scoreboard
    cyc(); u_if0.alloc_en = 1; u_if0.alloc_addr = 6; ra0(6, 6);
    expect_v("alloc_same", 0, 1, 0, 32'h3);
    cyc(); quiet0();
    expect_v("alloc_pend", 0, 1, 0, 32'h0);
    cyc(); wr0(6, 24'h000042);
    expect_v("wb_rdy", 0, 1, 0, 32'h3);
    expect_v("wb_byp", 0, 0, 1, 32'h42);
    cyc(); quiet0();
    expect_v("wb_rdy2", 0, 1, 0, 32'h3);
    expect_v("wb_arr", 0, 0, 0, 32'h42);
    cyc(); wr0(6, 24'h000077);
    u_if0.alloc_en = 1; u_if0.alloc_addr = 6;
    expect_v("race_byp", 0, 1, 0, 32'h3);
    cyc(); quiet0();
    expect_v("race_pend", 0, 1, 0, 32'h0);
    expect_v("race_data", 0, 0, 0, 32'h77);

    // bulk clear
    for (int i = 1; i < 8; i++) begin
      cyc(); wr0(i, 24'(i));
    end
    cyc(); quiet0();
    u_if0.alloc_en = 1; u_if0.alloc_addr = 2;
    cyc(); quiet0(); ra0(1, 2);
    u_if0.clr_req = 1;
    expect_v("pre_rdy", 0, 1, 0, 32'h2);
    expect_v("pre_busy", 0, 2, 0, 32'h0);
    expect_v("pre_r1", 0, 0, 1, 32'h1);
    for (int k = 1; k <= 7; k++) begin
      cyc(); quiet0();
      if (k == 2) begin
        u_if0.alloc_en = 1; u_if0.alloc_addr = 3;
      end
      if (k == 4) begin
        ra0(5, 1);
        expect_v("mid_r1", 0, 0, 0, 32'h0);
        expect_v("mid_r5", 0, 0, 1, 32'h5);
      end
      if (k == 6) begin
        wr0(1, 24'h000055); ra0(1, 1);
        expect_v("clr_nobyp", 0, 0, 0, 32'h0);
      end
      expect_v($sformatf("clr_busy%0d", k), 0, 2, 0, 32'h1);
      expect_v($sformatf("clr_rdy%0d", k), 0, 1, 0, 32'h3);
    end
    cyc(); quiet0();
    expect_v("clr_done", 0, 2, 0, 32'h0);
    for (int i = 1; i < 8; i++) begin
      cyc(); ra0(3, i);
      expect_v($sformatf("post_r%0d", i), 0, 0, 0, 32'h0);
      expect_v($sformatf("post_rdy%0d", i), 0, 1, 0, 32'h3);
    end

    // reset in the middle of a clear
    cyc(); wr0(5, 24'h0000A5);
    cyc(); wr0(6, 24'h0000A6);
    cyc(); quiet0(); u_if0.clr_req = 1; ra0(6, 5);
    cyc(); quiet0();
    cyc();
    expect_v("rc_busy2", 0, 2, 0, 32'h1);
    expect_v("rc_r5", 0, 0, 0, 32'hA5);
    cyc();
    #2 rst = 1'b0;
    #1;
    expect_v("rc_abort", 0, 2, 0, 32'h0);
    expect_v("rc_r5z", 0, 0, 0, 32'h0);
    expect_v("rc_r6z", 0, 0, 1, 32'h0);
    cyc(); rst = 1'b1;
    cyc();
    expect_v("rc_idle", 0, 2, 0, 32'h0);
    expect_v("rc_r6z2", 0, 0, 1, 32'h0);

    // wide instance
    cyc(); u_if1.we = 1; u_if1.wa = 4'd15;
    u_if1.wd = 32'hDEADBEEF;
    cyc(); u_if1.we = 0; u_if1.ra = {4'd15, 4'd15, 4'd15};
    for (int p = 0; p < 3; p++)
      expect_v($sformatf("w_r15_p%0d", p), 1, 0, p, 32'hDEADBEEF);
    expect_v("w_rdy", 1, 1, 0, 32'h7);
    u_if1.clr_req = 1;
    for (int k = 1; k <= 15; k++) begin
      cyc(); u_if1.clr_req = 0;
      expect_v($sformatf("w_busy%0d", k), 1, 2, 0, 32'h1);
    end
    cyc();
    expect_v("w_done", 1, 2, 0, 32'h0);
    expect_v("w_r15z", 1, 0, 2, 32'h0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
